// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op/state encodings for the multiply/divide unit
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIVU = 2'b01,
        MD_DIV  = 2'b10,
        MD_MOD  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    // Without signed support the signed ops collapse onto DIVU.
    function automatic md_op_e md_eff_op(input logic [1:0] op, input bit signed_en);
        if (!signed_en && op[1]) begin
            return MD_DIVU;
        end
        return md_op_e'(op);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between execute stage and muldiv unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic             dz;

    modport master (
        output start, flush, op, din_a, din_b,
        input  busy, done, dout, vout, dz
    );

    modport slave (
        input  start, flush, op, din_a, din_b,
        output busy, done, dout, vout, dz
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add or restoring-divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_is_div,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    // MUL: {hi,multiplier} shifts right, adding the multiplicand when the LSB is set.
    // DIV: {rem,dividend} shifts left; the partial remainder is kept when the trial subtract goes negative.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
        if (!i_is_div) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with FSM, sign fix-up and result registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_unit_if.slave  io
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    md_op_e             r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_ovf;
    logic               r_dz;
    logic [WIDTH-1:0]   r_dout;
    logic               r_vout;
    logic               r_dz_out;

    md_op_e             w_op_in;
    logic               w_sdiv_in;
    logic               w_dz_in;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_v;
    logic               w_res_dz;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    assign w_op_in   = md_eff_op(io.op, SIGNED);
    assign w_sdiv_in = (w_op_in == MD_DIV) || (w_op_in == MD_MOD);
    assign w_dz_in   = (w_op_in != MD_MUL) && (io.din_b == '0);
    assign w_accept  = io.start && !io.flush && ((r_state == MD_IDLE) || (r_state == MD_DONE));
    assign w_abs_a   = (w_sdiv_in && io.din_a[WIDTH-1]) ? -io.din_a : io.din_a;
    assign w_abs_b   = (w_sdiv_in && io.din_b[WIDTH-1]) ? -io.din_b : io.din_b;
    assign w_q       = r_acc[WIDTH-1:0];
    assign w_r       = r_acc[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_is_div (r_op != MD_MUL),
        .o_acc    (w_acc_step)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus busy/done decode; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        io.busy     = 1'b0;
        io.done     = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_accept) w_state_nxt = w_dz_in ? MD_FIX : MD_CALC;
            end
            MD_CALC: begin
                io.busy = 1'b1;
                if (r_cnt == LAST_CNT) w_state_nxt = MD_FIX;
            end
            MD_FIX: begin
                io.busy     = 1'b1;
                w_state_nxt = MD_DONE;
            end
            MD_DONE: begin
                io.done = 1'b1;
                if (w_accept) w_state_nxt = w_dz_in ? MD_FIX : MD_CALC;
                else          w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
        if (io.flush) w_state_nxt = MD_IDLE;
    end

    // Final result selection: sign fix-up, divide-by-zero values and overflow flag.
    always_comb begin
        w_res    = w_q;
        w_res_v  = 1'b0;
        w_res_dz = r_dz;
        case (r_op)
            MD_MUL: begin
                w_res    = w_q;
                w_res_v  = |w_r;
                w_res_dz = 1'b0;
            end
            MD_DIVU: begin
                w_res = r_dz ? ALL_ONES : w_q;
            end
            MD_DIV: begin
                w_res   = r_dz ? ALL_ONES : ((r_sign_a ^ r_sign_b) ? -w_q : w_q);
                w_res_v = r_ovf;
            end
            MD_MOD: begin
                // On divide-by-zero the low half still holds the raw dividend.
                w_res = r_dz ? w_q : (r_sign_a ? -w_r : w_r);
            end
            default: w_res = w_q;
        endcase
    end

    // Operand capture on accept, one step per CALC cycle, outputs loaded only on DONE entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= MD_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_dout   <= '0;
            r_vout   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= w_op_in;
                r_cnt    <= '0;
                r_sign_a <= w_sdiv_in && io.din_a[WIDTH-1];
                r_sign_b <= w_sdiv_in && io.din_b[WIDTH-1];
                r_ovf    <= (w_op_in == MD_DIV) && (io.din_a == MIN_VAL) && (io.din_b == ALL_ONES);
                r_dz     <= w_dz_in;
                // Upper half cleared; the operand that gets consumed bit-serially sits in the lower half.
                if (w_op_in == MD_MUL) begin
                    r_acc  <= {{WIDTH{1'b0}}, io.din_b};
                    r_opnd <= io.din_a;
                end else if (w_dz_in) begin
                    r_acc  <= {{WIDTH{1'b0}}, io.din_a};
                    r_opnd <= io.din_b;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                    r_opnd <= w_abs_b;
                end
            end else if (r_state == MD_CALC) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == MD_FIX) && !io.flush) begin
                r_dout   <= w_res;
                r_vout   <= w_res_v;
                r_dz_out <= w_res_dz;
            end
        end
    end

    assign io.dout = r_dout;
    assign io.vout = r_vout;
    assign io.dz   = r_dz_out;

endmodule
